cmp_lteq_sched: RTL and testbench
=================================

# cmp_lteq_sched

Shared-resource scheduler for the 32-bit unsigned less-than-or-equal comparator datapath. Arbitrates `NREQ` requesters round-robin onto a single comparator instance, registers the operands, and returns each result tagged with the requester index over a valid/ready response channel. Sits between crypto-benchmark clients (MPC/garbled-circuit evaluation loops) and the comparator, so one comparator serves several independent callers.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: operand width in bits. The comparator is defined for 32; other values use the same generic function.
- `IDW`, $clog2(NREQ): requester-index width (derived localparam).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand b; same slicing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_lteq`  out  1  1 iff a <= b, unsigned.

## Operation
- A transfer from requester i happens on a cycle where `req_valid[i]` and `req_ready[i]` are both 1. A response transfer happens on a cycle where `rsp_valid` and `rsp_ready` are both 1.
- Arbitration:
  - Round-robin pointer `last` holds the index of the most recent grant. Reset value is NREQ-1, so requester 0 has first priority.
  - The search order is last+1, last+2, … modulo NREQ. The first requester found with valid=1 wins.
  - `last` updates only when a transfer actually occurs.
- `req_ready` is combinational. It is the winner's one-hot when the pipeline can accept, otherwise all zeros. It never depends on the requester's own `req_ready`.
- Pipeline can accept when the operand stage is empty, or when it drains this cycle.
- Operand stage, one entry: holds `{a, b, id}` and an occupancy bit.
- The comparator sub-module evaluates the stored operands. Its result is unsigned a <= b on WIDTH bits with no sign extension: a==b gives 1, and a=0 gives 1 for any b.
- Backpressure:
  - While `rsp_valid` is 1 and `rsp_ready` is 0, every output (`rsp_valid`, `rsp_id`, `rsp_lteq`) holds stable and no new grant is issued.
  - A requester holding valid=1 and not granted keeps its request. The block never drops a request.
- Requesters must hold their operands stable until accepted. The block samples operands only on the transfer cycle.
- Simultaneous drain and grant in the same cycle is required, for full throughput.
- Reset mid-operation: in-flight entries are discarded, `rsp_valid` goes to 0, and `last` returns to NREQ-1. No response is emitted for the discarded entries.

## Timing
- Reset values:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_lteq` = 0.
  - `req_ready` = 0 during reset.
  - Occupancy bits = 0.
- Latency from request transfer at cycle t to `rsp_valid` high:
  - t+1 without the result register.
  - t+2 with it.
- Throughput: one comparison per cycle when `rsp_ready` is held at 1.
- Fairness: a continuously asserted request is granted within NREQ accepting cycles.

## Configuration
- `CMP_SCHED_RESULT_REG_EN` defined:
  - A second pipeline register captures `{id, lteq}` after the comparator, so the comparator output path ends at a flop.
  - Latency is 2 and the pipeline holds 2 entries.
  - The stall and drain rules above apply stage by stage. A stage may load when it is empty or when its downstream stage drains.
- `CMP_SCHED_RESULT_REG_EN` undefined:
  - The comparator output drives `rsp_lteq` directly from the operand stage.
  - Latency is 1.

## Structure
- Package `cmp_sched_pkg` holds:
  - the default `WIDTH` constant;
  - the `cmp_op_t` struct `{a, b}`;
  - the `cmp_rsp_t` struct `{id, lteq}`.
- Sub-module `cmp_lteq_u` is the purely combinational WIDTH-bit unsigned <= comparator. It is instantiated once. It can be swapped for the gate-level netlist for equivalence checks.
- Round-robin selection lives inline in the scheduler, not in a separate module.

## Test plan
- Single request, no configuration macro: req 2 sends a=0x0000_0005, b=0x0000_0005. Required: `rsp_valid` at t+1 with `rsp_id`=2 and `rsp_lteq`=1.
- Unsigned edges: a=0x8000_0000, b=0x7FFF_FFFF gives 0. a=0, b=0xFFFF_FFFF gives 1. a=0xFFFF_FFFF, b=0xFFFF_FFFF gives 1.
- All four requesters valid continuously, `rsp_ready`=1. Required: grants in order 0,1,2,3,0,…, one per cycle, with `rsp_id` following the same order after the configured latency.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with 2 requesters active. Required:
  - outputs stable for all 5 cycles;
  - `req_ready` all 0 once the pipeline is full;
  - no loss or duplication after release.
- Reset asserted while an entry is in flight. Required:
  - `rsp_valid`=0 on the next cycle;
  - the first grant after reset goes to requester 0 when all requesters are valid.
- With `CMP_SCHED_RESULT_REG_EN` defined: repeat the first scenario, and `rsp_valid` must rise at t+2. Random streams must match a reference model of (a <= b) for 10k transactions.

Source files
------------

// File: rtl/cmp_lteq_sched_pkg.sv
// cmp_sched_pkg: shared constants and operand/result record types for the comparator scheduler
package cmp_sched_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_IDW = 4;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } cmp_op_t;
  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic               lteq;
  } cmp_rsp_t;
endpackage

// File: rtl/cmp_lteq_sched_if.sv
// cmp_lteq_sched_if: requester operand channels and tagged response channel of the comparator scheduler
interface cmp_lteq_sched_if
  import cmp_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
) ();
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_lteq;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lteq
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lteq
  );
endinterface

// File: rtl/cmp_lteq_sched_cmp.sv
// cmp_lteq_u: purely combinational unsigned a <= b comparator, swappable for a gate-level netlist
module cmp_lteq_u
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lteq
);
  assign lteq = a <= b;
endmodule

// File: rtl/cmp_lteq_sched.sv
// cmp_lteq_sched: round-robin scheduler sharing one unsigned <= comparator; CMP_SCHED_RESULT_REG_EN adds a result register stage
module cmp_lteq_sched
  import cmp_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             rst,
  cmp_lteq_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  logic [IDW-1:0]   last_q, last_d, win, idx;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             occ_q, occ_d, any, can_acc, drain, xfer, lteq;

  cmp_lteq_u #(.WIDTH(WIDTH)) u_cmp (.a(a_q), .b(b_q), .lteq(lteq));

  // first valid requester searching from the one after the last grant
  always_comb begin
    win = last_q;
    idx = last_q;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!any && bus.req_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  // grant, operand capture and pointer advance happen only on an actual transfer
  always_comb begin
    xfer = any && can_acc && !rst;
    bus.req_ready = xfer ? (NREQ'(1) << win) : '0;
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && win == IDW'(i)) begin
        a_d = bus.req_a[i*WIDTH +: WIDTH];
        b_d = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    id_d = xfer ? win : id_q;
    last_d = xfer ? win : last_q;
    occ_d = xfer || (occ_q && !drain);
  end

  // operand stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
      occ_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
    end else begin
      last_q <= last_d;
      occ_q <= occ_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
    end
  end

`ifdef CMP_SCHED_RESULT_REG_EN
  logic     res_occ_q, res_occ_d;
  cmp_rsp_t res_q, res_d;

  // result stage loads when empty or draining; the operand stage drains into it
  always_comb begin
    drain = occ_q && (!res_occ_q || bus.rsp_ready);
    can_acc = !occ_q || drain;
    res_occ_d = drain || (res_occ_q && !bus.rsp_ready);
    res_d = drain ? '{id: MAX_IDW'(id_q), lteq: lteq} : res_q;
    bus.rsp_valid = res_occ_q;
    bus.rsp_id = IDW'(res_q.id);
    bus.rsp_lteq = res_q.lteq;
  end

  // result register so the comparator path ends at a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      res_occ_q <= 1'b0;
      res_q <= '0;
    end else begin
      res_occ_q <= res_occ_d;
      res_q <= res_d;
    end
  end
`else
  // response comes straight from the operand stage; lteq gated so an idle stage reads 0
  always_comb begin
    drain = occ_q && bus.rsp_ready;
    can_acc = !occ_q || bus.rsp_ready;
    bus.rsp_valid = occ_q;
    bus.rsp_id = id_q;
    bus.rsp_lteq = occ_q && lteq;
  end
`endif
endmodule

// File: tb/tb_cmp_lteq_sched.sv
// tb_cmp_lteq_sched: directed and randomized self-checking bench for cmp_lteq_sched
module tb_cmp_lteq_sched;
  import cmp_sched_pkg::*;
`ifdef CMP_SCHED_RESULT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NTX = 10000;

  typedef struct {
    int   id;
    logic lteq;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      n_chk = 0;
  int      n_pass = 0;
  exp_t    q[$];
  exp_t    e;
  cmp_op_t cur[4];
  logic [3:0] pend;
  int      issued, got;

  cmp_lteq_sched_if #(.NREQ(4), .WIDTH(32)) bus ();
  cmp_lteq_sched #(.NREQ(4), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b, input logic exp_l);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
    #1 check("single_rdy", bus.req_ready, 64'(4'b1 << id));
    for (int n = 1; n <= LAT; n++) begin
      tick();
      if (n == 1) bus.req_valid = '0;
      check("single_vld", bus.rsp_valid, 64'(n == LAT));
    end
    check("single_id", bus.rsp_id, 64'(id));
    check("single_lteq", bus.rsp_lteq, 64'(exp_l));
    tick();
    check("single_drain", bus.rsp_valid, 0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '1;
    #1 check("rst_rdy", bus.req_ready, 0);
    check("rst_vld", bus.rsp_valid, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_lteq", bus.rsp_lteq, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
    single(2, 32'h0000_0005, 32'h0000_0005, 1'b1);
    single(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    single(3, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    single(2, 32'h0000_0001, 32'h0000_0000, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*32 +: 32] = 32'(i);
      bus.req_b[i*32 +: 32] = 32'd1;
    end
    bus.req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1 check("rr_rdy", bus.req_ready, 64'(4'b1 << (c % 4)));
      check("rr_vld", bus.rsp_valid, 64'(c >= LAT));
      if (c >= LAT) begin
        check("rr_id", bus.rsp_id, 64'((c - LAT) % 4));
        check("rr_lteq", bus.rsp_lteq, 64'(((c - LAT) % 4) <= 1));
      end
      tick();
    end
    bus.req_valid = '0;
    repeat (LAT + 1) tick();
    check("rr_drain", bus.rsp_valid, 0);

    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_a[0 +: 32] = 32'd10;
    bus.req_b[0 +: 32] = 32'd20;
    bus.req_a[32 +: 32] = 32'd30;
    bus.req_b[32 +: 32] = 32'd20;
    bus.req_valid = 4'b0011;
    #1 check("bp_first_rdy", bus.req_ready, 64'b0001);
    repeat (LAT) tick();
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_vld", bus.rsp_valid, 1);
      check("bp_id", bus.rsp_id, 0);
      check("bp_lteq", bus.rsp_lteq, 1);
      check("bp_rdy", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("rel_vld", bus.rsp_valid, 1);
      check("rel_id", bus.rsp_id, 64'(k % 2));
      check("rel_lteq", bus.rsp_lteq, 64'(k % 2 == 0));
      tick();
    end
    bus.req_valid = '0;
    repeat (LAT + 1) tick();
    check("bp_drain", bus.rsp_valid, 0);

    bus.req_a[96 +: 32] = 32'd1;
    bus.req_b[96 +: 32] = 32'd2;
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 4'hF;
    rst = 1'b1;
    #1 check("mrst_rdy", bus.req_ready, 0);
    tick();
    check("mrst_vld", bus.rsp_valid, 0);
    check("mrst_lteq", bus.rsp_lteq, 0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 check("mrst_grant", bus.req_ready, 64'b0001);
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    check("mrst_rsp_vld", bus.rsp_valid, 1);
    check("mrst_rsp_id", bus.rsp_id, 0);
    tick();
    check("mrst_drain", bus.rsp_valid, 0);

    pend = '0;
    issued = 0;
    got = 0;
    for (int cyc = 0; cyc < 60000 && got < NTX; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && issued < NTX && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          issued++;
          cur[i].a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          cur[i].b = ($urandom_range(0, 3) == 0) ? cur[i].a : $urandom;
          bus.req_a[i*32 +: 32] = cur[i].a;
          bus.req_b[i*32 +: 32] = cur[i].b;
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i]) begin
          q.push_back('{id: i, lteq: cur[i].a <= cur[i].b});
          pend[i] = 1'b0;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) check("rnd_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("rnd_id", bus.rsp_id, 64'(e.id));
          check("rnd_lteq", bus.rsp_lteq, 64'(e.lteq));
          got++;
        end
      end
      tick();
    end
    check("rnd_count", got, NTX);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
